// File: rtl/adc_pkg.sv
// Shared types and constants for the ADC result readout path.
package adc_pkg;

  localparam int unsigned ADC_RESULT_WIDTH = 10;

  typedef enum logic [1:0] {
    DISABLED = 2'b00,
    ARMED    = 2'b01,
    RUNNING  = 2'b10
  } adc_state_t;

endpackage

// File: rtl/adc_sync_edge.sv
// Two-flop synchroniser for an asynchronous strobe, plus a single-cycle rising-edge pulse.
module adc_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic sync_out,
  output logic rise_c
);

  logic meta_q;
  logic sync_q;
  logic dly_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      dly_q  <= 1'b0;
    end else begin
      meta_q <= async_in;
      sync_q <= meta_q;
      dly_q  <= sync_q;
    end
  end

  assign sync_out = sync_q;
  assign rise_c   = sync_q & ~dly_q;

endmodule

// File: rtl/adc_result_buffer.sv
// Captures finished ADC results into a show-ahead FIFO and presents them on a
// valid/ready stream with level, threshold IRQ, sticky overflow and sample count.
module adc_result_buffer
  import adc_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = ADC_RESULT_WIDTH,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enable_in,
  input  logic [DATA_WIDTH-1:0]    result_in,
  input  logic                     conv_finished_in,
  input  logic [$clog2(DEPTH):0]   threshold_in,
  input  logic                     clear_overflow_in,
  output logic [DATA_WIDTH-1:0]    data_out,
  output logic                     valid_out,
  input  logic                     ready_in,
  output logic [$clog2(DEPTH):0]   level_out,
  output logic                     irq_out,
  output logic                     overflow_out,
  output logic [CNT_WIDTH-1:0]     sample_count_out
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  adc_state_t state_q;
  adc_state_t state_nxt;
  logic       running_c;

  logic strobe_sync;
  logic cap_c;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]         wr_ptr_q;
  logic [PW-1:0]         rd_ptr_q;
  logic [PW-1:0]         wr_ptr_nxt;
  logic [PW-1:0]         rd_ptr_nxt;
  logic [PW-1:0]         level_nxt;
  logic [AW-1:0]         rd_addr_nxt;
  logic [DATA_WIDTH-1:0] head_c;
  logic                  full_c;
  logic                  rd_c;
  logic                  wr_c;
  logic                  drop_c;

  adc_sync_edge u_sync (
    .clk      (clk),
    .rst      (rst),
    .async_in (conv_finished_in),
    .sync_out (strobe_sync),
    .rise_c   (cap_c)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= DISABLED;
    else     state_q <= state_nxt;
  end

  // ARMED waits for the strobe to be low so a conversion already in flight is not captured.
  always_comb begin
    state_nxt = state_q;
    running_c = 1'b0;
    case (state_q)
      DISABLED: begin
        if (enable_in) state_nxt = ARMED;
      end
      ARMED: begin
        if (!enable_in)       state_nxt = DISABLED;
        else if (!strobe_sync) state_nxt = RUNNING;
      end
      RUNNING: begin
        running_c = 1'b1;
        if (!enable_in) state_nxt = DISABLED;
      end
      default: state_nxt = DISABLED;
    endcase
  end

  always_comb begin
    full_c      = (level_out == PW'(DEPTH));
    rd_c        = valid_out & ready_in;
    wr_c        = cap_c & running_c & (~full_c | rd_c);
    drop_c      = cap_c & running_c & full_c & ~rd_c;
    wr_ptr_nxt  = wr_ptr_q + PW'(wr_c);
    rd_ptr_nxt  = rd_ptr_q + PW'(rd_c);
    level_nxt   = wr_ptr_nxt - rd_ptr_nxt;
    rd_addr_nxt = rd_ptr_nxt[AW-1:0];
    // Writing into an empty FIFO: the new entry becomes the head on the same edge.
    if (wr_c && (wr_ptr_q[AW-1:0] == rd_addr_nxt)) head_c = result_in;
    else                                           head_c = mem[rd_addr_nxt];
  end

  always_ff @(posedge clk) begin
    if (wr_c && !rst) mem[wr_ptr_q[AW-1:0]] <= result_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q         <= '0;
      rd_ptr_q         <= '0;
      level_out        <= '0;
      valid_out        <= 1'b0;
      data_out         <= '0;
      irq_out          <= 1'b0;
      overflow_out     <= 1'b0;
      sample_count_out <= '0;
    end else begin
      wr_ptr_q         <= wr_ptr_nxt;
      rd_ptr_q         <= rd_ptr_nxt;
      level_out        <= level_nxt;
      valid_out        <= (level_nxt != '0);
      if (level_nxt != '0) data_out <= head_c;
      irq_out          <= (threshold_in != '0) && (level_out >= threshold_in);
      overflow_out     <= drop_c | (overflow_out & ~clear_overflow_in);
      sample_count_out <= sample_count_out + CNT_WIDTH'(wr_c);
    end
  end

endmodule

// File: tb/tb_adc_result_buffer.sv
// Directed self-checking bench for adc_result_buffer (DEPTH=16, 10-bit results).
module tb_adc_result_buffer;

  localparam int unsigned DW    = 10;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned CW    = 16;
  localparam int unsigned LW    = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          enable_in;
  logic [DW-1:0] result_in;
  logic          conv_finished_in;
  logic [LW-1:0] threshold_in;
  logic          clear_overflow_in;
  logic [DW-1:0] data_out;
  logic          valid_out;
  logic          ready_in;
  logic [LW-1:0] level_out;
  logic          irq_out;
  logic          overflow_out;
  logic [CW-1:0] sample_count_out;

  int total = 0;
  int bad   = 0;

  adc_result_buffer #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .CNT_WIDTH(CW)) dut (
    .clk               (clk),
    .rst               (rst),
    .enable_in         (enable_in),
    .result_in         (result_in),
    .conv_finished_in  (conv_finished_in),
    .threshold_in      (threshold_in),
    .clear_overflow_in (clear_overflow_in),
    .data_out          (data_out),
    .valid_out         (valid_out),
    .ready_in          (ready_in),
    .level_out         (level_out),
    .irq_out           (irq_out),
    .overflow_out      (overflow_out),
    .sample_count_out  (sample_count_out)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One strobe: high for two cycles, low for two; the write lands on the third edge.
  task automatic strobe(input logic [DW-1:0] v);
    result_in        = v;
    conv_finished_in = 1'b1;
    tick(2);
    conv_finished_in = 1'b0;
    tick(2);
  endtask

  task automatic do_reset_enable();
    rst = 1'b1; enable_in = 1'b0; ready_in = 1'b0;
    tick(2);
    rst = 1'b0; enable_in = 1'b1;
    tick(2);
  endtask

  task automatic test_reset();
    do_reset_enable();
    total++; if (valid_out !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", valid_out); end
    total++; if (level_out !== 5'd0) begin bad++; $display("FAIL reset_level got=%0d exp=0", level_out); end
    total++; if (data_out !== 10'd0) begin bad++; $display("FAIL reset_data got=%h exp=0", data_out); end
    total++; if (sample_count_out !== 16'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", sample_count_out); end
    total++; if (irq_out !== 1'b0 || overflow_out !== 1'b0) begin bad++; $display("FAIL reset_flags got irq=%b ovf=%b exp=0,0", irq_out, overflow_out); end
  endtask

  task automatic test_single_capture();
    result_in = 10'h2A5; conv_finished_in = 1'b1;
    tick(2);
    total++; if (valid_out !== 1'b0) begin bad++; $display("FAIL single_early_valid got=%b exp=0", valid_out); end
    tick(1);
    total++; if (valid_out !== 1'b1 || data_out !== 10'h2A5) begin bad++; $display("FAIL single_capture got v=%b d=%h exp=1,2a5", valid_out, data_out); end
    total++; if (level_out !== 5'd1 || sample_count_out !== 16'd1) begin bad++; $display("FAIL single_level_count got=%0d,%0d exp=1,1", level_out, sample_count_out); end
    conv_finished_in = 1'b0;
    tick(2);
    total++; if (data_out !== 10'h2A5) begin bad++; $display("FAIL single_hold got=%h exp=2a5", data_out); end
    ready_in = 1'b1; tick(1); ready_in = 1'b0;
    total++; if (valid_out !== 1'b0 || level_out !== 5'd0) begin bad++; $display("FAIL single_drain got v=%b l=%0d exp=0,0", valid_out, level_out); end
  endtask

  task automatic test_fill_overflow();
    for (int i = 0; i < 16; i++) strobe(10'(i));
    total++; if (level_out !== 5'd16 || overflow_out !== 1'b0) begin bad++; $display("FAIL fill_full got l=%0d o=%b exp=16,0", level_out, overflow_out); end
    total++; if (irq_out !== 1'b0) begin bad++; $display("FAIL fill_irq_thr0 got=%b exp=0", irq_out); end
    strobe(10'd16);
    total++; if (level_out !== 5'd16 || overflow_out !== 1'b1) begin bad++; $display("FAIL fill_overflow got l=%0d o=%b exp=16,1", level_out, overflow_out); end
    total++; if (sample_count_out !== 16'd17) begin bad++; $display("FAIL fill_count got=%0d exp=17", sample_count_out); end
    ready_in = 1'b1;
    for (int i = 0; i < 16; i++) begin
      total++; if (valid_out !== 1'b1 || data_out !== 10'(i)) begin bad++; $display("FAIL fill_drain[%0d] got v=%b d=%0d exp=1,%0d", i, valid_out, data_out, i); end
      tick(1);
    end
    ready_in = 1'b0;
    total++; if (valid_out !== 1'b0 || overflow_out !== 1'b1) begin bad++; $display("FAIL fill_empty got v=%b o=%b exp=0,1", valid_out, overflow_out); end
    clear_overflow_in = 1'b1; tick(1); clear_overflow_in = 1'b0;
    total++; if (overflow_out !== 1'b0) begin bad++; $display("FAIL fill_clear got=%b exp=0", overflow_out); end
  endtask

  task automatic test_full_read();
    for (int i = 0; i < 16; i++) strobe(10'(100 + i));
    result_in = 10'h3FF; conv_finished_in = 1'b1;
    tick(2);
    ready_in = 1'b1; tick(1); ready_in = 1'b0;
    conv_finished_in = 1'b0; tick(1);
    total++; if (level_out !== 5'd16 || overflow_out !== 1'b0) begin bad++; $display("FAIL fullrd_level got l=%0d o=%b exp=16,0", level_out, overflow_out); end
    total++; if (sample_count_out !== 16'd34) begin bad++; $display("FAIL fullrd_count got=%0d exp=34", sample_count_out); end
    ready_in = 1'b1;
    for (int i = 1; i < 17; i++) begin
      logic [DW-1:0] exp_v;
      exp_v = (i == 16) ? 10'h3FF : 10'(100 + i);
      total++; if (data_out !== exp_v) begin bad++; $display("FAIL fullrd_drain[%0d] got=%h exp=%h", i, data_out, exp_v); end
      tick(1);
    end
    ready_in = 1'b0;
    total++; if (valid_out !== 1'b0) begin bad++; $display("FAIL fullrd_empty got=%b exp=0", valid_out); end
  endtask

  task automatic test_enable_during_strobe();
    enable_in = 1'b0; tick(1);
    conv_finished_in = 1'b1; result_in = 10'h111;
    tick(4);
    enable_in = 1'b1;
    tick(6);
    total++; if (level_out !== 5'd0 || sample_count_out !== 16'd34) begin bad++; $display("FAIL en_strobe_held got l=%0d c=%0d exp=0,34", level_out, sample_count_out); end
    conv_finished_in = 1'b0;
    tick(4);
    total++; if (level_out !== 5'd0) begin bad++; $display("FAIL en_strobe_fall got=%0d exp=0", level_out); end
    strobe(10'h155);
    total++; if (level_out !== 5'd1 || data_out !== 10'h155) begin bad++; $display("FAIL en_strobe_cap got l=%0d d=%h exp=1,155", level_out, data_out); end
    ready_in = 1'b1; tick(1); ready_in = 1'b0;
  endtask

  task automatic test_threshold_wrap();
    do_reset_enable();
    threshold_in = 5'd4;
    strobe(10'd10); strobe(10'd11); strobe(10'd12);
    total++; if (level_out !== 5'd3 || irq_out !== 1'b0) begin bad++; $display("FAIL irq_below got l=%0d i=%b exp=3,0", level_out, irq_out); end
    result_in = 10'd13; conv_finished_in = 1'b1;
    tick(2); conv_finished_in = 1'b0; tick(1);
    total++; if (level_out !== 5'd4 || irq_out !== 1'b0) begin bad++; $display("FAIL irq_lag got l=%0d i=%b exp=4,0", level_out, irq_out); end
    tick(1);
    total++; if (irq_out !== 1'b1) begin bad++; $display("FAIL irq_set got=%b exp=1", irq_out); end
    total++; if (data_out !== 10'd10) begin bad++; $display("FAIL irq_head got=%0d exp=10", data_out); end
    ready_in = 1'b1; tick(1); ready_in = 1'b0;
    total++; if (level_out !== 5'd3 || irq_out !== 1'b1) begin bad++; $display("FAIL irq_read_lag got l=%0d i=%b exp=3,1", level_out, irq_out); end
    tick(1);
    total++; if (irq_out !== 1'b0) begin bad++; $display("FAIL irq_clear got=%b exp=0", irq_out); end
    ready_in = 1'b1; tick(3); ready_in = 1'b0;
    for (int i = 0; i < 40; i++) begin
      logic [DW-1:0] v;
      v = 10'(i * 37 + 5);
      strobe(v);
      total++; if (level_out !== 5'd1 || data_out !== v) begin bad++; $display("FAIL wrap_data[%0d] got l=%0d d=%h exp=1,%h", i, level_out, data_out, v); end
      ready_in = 1'b1; tick(1); ready_in = 1'b0;
    end
    total++; if (level_out !== 5'd0 || sample_count_out !== 16'd44) begin bad++; $display("FAIL wrap_count got l=%0d c=%0d exp=0,44", level_out, sample_count_out); end
    threshold_in = 5'd0;
  endtask

  task automatic test_reset_midstream();
    for (int i = 0; i < 5; i++) strobe(10'(500 + i));
    total++; if (level_out !== 5'd5 || sample_count_out !== 16'd49) begin bad++; $display("FAIL mid_pre got l=%0d c=%0d exp=5,49", level_out, sample_count_out); end
    rst = 1'b1; enable_in = 1'b0; conv_finished_in = 1'b1; result_in = 10'h0AA;
    tick(1);
    rst = 1'b0;
    total++; if (valid_out !== 1'b0 || level_out !== 5'd0 || data_out !== 10'd0) begin bad++; $display("FAIL mid_reset got v=%b l=%0d d=%h exp=0,0,0", valid_out, level_out, data_out); end
    total++; if (sample_count_out !== 16'd0 || overflow_out !== 1'b0) begin bad++; $display("FAIL mid_reset_cnt got c=%0d o=%b exp=0,0", sample_count_out, overflow_out); end
    tick(3);
    enable_in = 1'b1;
    tick(4);
    total++; if (level_out !== 5'd0 || valid_out !== 1'b0) begin bad++; $display("FAIL mid_strobe_ignored got l=%0d v=%b exp=0,0", level_out, valid_out); end
    conv_finished_in = 1'b0;
    tick(4);
    strobe(10'h1C3);
    total++; if (level_out !== 5'd1 || data_out !== 10'h1C3 || sample_count_out !== 16'd1) begin bad++; $display("FAIL mid_recover got l=%0d d=%h c=%0d exp=1,1c3,1", level_out, data_out, sample_count_out); end
  endtask

  initial begin
    rst = 1'b1; enable_in = 1'b0; result_in = '0; conv_finished_in = 1'b0;
    threshold_in = '0; clear_overflow_in = 1'b0; ready_in = 1'b0;
    test_reset();
    test_single_capture();
    test_fill_overflow();
    test_full_read();
    test_enable_during_strobe();
    test_threshold_wrap();
    test_reset_midstream();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/adc_result_buffer.md
Name: adc_result_buffer

Overview:
- Downstream consumer of the SAR-ADC core digital block's OSR result (10-bit result plus conversion-finished strobe).
- Synchronises the strobe into the system clock domain and captures each finished result into a small FIFO.
- Presents results on a valid/ready stream with level, threshold-IRQ, overflow and sample-count status.
- Sits between the ADC core and the system bus / readout logic.

Parameters:
- DATA_WIDTH, 10, result width; must equal the ADC core result width.
- DEPTH, 16, FIFO entries; power of two, range 2..256.
- CNT_WIDTH, 16, width of the accepted-sample counter.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; synchronous, active-high.
- enable_in  in  1  capture enable.
- result_in  in  DATA_WIDTH  OSR result from the ADC core.
- conv_finished_in  in  1  OSR conversion-finished strobe; asynchronous to clk.
- threshold_in  in  $clog2(DEPTH)+1  IRQ level threshold.
- clear_overflow_in  in  1  clears the sticky overflow flag.
- data_out  out  DATA_WIDTH  FIFO head entry.
- valid_out  out  1  FIFO non-empty.
- ready_in  in  1  consumer accept.
- level_out  out  $clog2(DEPTH)+1  current occupancy.
- irq_out  out  1  high while level_out >= threshold_in and threshold_in != 0.
- overflow_out  out  1  sticky: a result was dropped because the FIFO was full.
- sample_count_out  out  CNT_WIDTH  count of accepted writes; wraps.

Behaviour:
- Reset (rst high at a clk edge):
  - Clears synchroniser flops, pointers, level, overflow and counter.
  - FSM goes to DISABLED.
  - Reset values: valid_out=0, irq_out=0, overflow_out=0, level_out=0, sample_count_out=0, data_out=0.
  - Reset mid-stream discards all FIFO contents; no partial write completes.
- Strobe synchronisation: 2-flop synchroniser, then a third flop for rising-edge detect. A single `cap` pulse is produced per strobe rising edge.
- result_in sampling:
  - Sampled directly on the `cap` cycle, with no synchroniser.
  - Guaranteed stable for at least 4 clk cycles after the strobe rises; the OSR output holds until the next conversion.
- FSM:
  - DISABLED: no capture. Goes to ARMED when enable_in=1.
  - ARMED: waits until the synchronised strobe is 0. This prevents capturing a strobe already in progress at enable time. Then goes to RUNNING. If enable_in=0, returns to DISABLED.
  - RUNNING: each `cap` requests a write. If enable_in=0, goes to DISABLED; FIFO contents are retained and remain readable in every state.
- Write/read:
  - write = cap & RUNNING & (!full | read).
  - read = valid_out & ready_in.
  - Capture latency: strobe high before edge E0 → write at E2 → valid_out high and data_out valid after E2.
- Full FIFO:
  - cap while full with no read in the same cycle: data dropped; overflow_out set on the next edge.
  - cap while full with a read in the same cycle: write accepted, level unchanged.
- Empty FIFO:
  - No bypass; valid_out rises only after the write edge.
  - A read when empty is impossible, since valid_out=0.
- Simultaneous read and write (non-full): level unchanged, both pointers advance.
- Pointers:
  - $clog2(DEPTH)+1 bits, with the MSB used for full/empty; wrap-around is natural.
  - level_out = wr_ptr - rd_ptr.
- data_out: memory at rd_ptr (show-ahead). It is held while valid_out=1 and ready_in=0.
- overflow_out: sticky. clear_overflow_in clears it; if a drop occurs in the same cycle as the clear, the flag stays set.
- sample_count_out: increments on each accepted write; wraps from 2^CNT_WIDTH-1 to 0.
- irq_out: registered from level_out versus threshold_in, so it lags the level by one cycle.

Decomposition:
- Shared package adc_pkg contains:
  - ADC_RESULT_WIDTH=10.
  - The FSM state typedef: DISABLED=2'b00, ARMED=2'b01, RUNNING=2'b10.
- One sub-module, adc_sync_edge: 2-flop synchroniser plus rising-edge pulse, with synchronous active-high reset.
- FIFO storage and pointers are inline in adc_result_buffer.

Test Plan:
1. Single capture:
   - Stimulus: after reset, enable_in=1, result_in=10'h2A5, one strobe pulse, ready_in=0.
   - Required: valid_out=1 and data_out=10'h2A5 at the 3rd clk edge after the strobe; level_out=1; sample_count_out=1.
2. Fill and overflow:
   - Stimulus: DEPTH=16, 17 strobes with results 0..16, ready_in=0.
   - Required: level_out=16; overflow_out=1; drain yields 0..15 in order; value 16 is lost.
   - Then pulse clear_overflow_in: overflow_out=0.
3. Full plus simultaneous read:
   - Stimulus: FIFO full, ready_in=1 in the same cycle a strobe is captured with result 10'h3FF.
   - Required: level stays 16, overflow_out stays 0, 10'h3FF is the last entry drained.
4. Enable during strobe:
   - Stimulus: strobe held high, enable_in raised.
   - Required: no capture until the strobe falls and rises again; FSM goes ARMED → RUNNING.
5. Threshold IRQ and wrap:
   - Stimulus: threshold_in=4, 4 captures.
   - Required: irq_out=1 one cycle after level_out reaches 4; one read clears it.
   - Run 40 write/read pairs: pointers wrap, data integrity is kept, sample_count_out=44.
6. Reset mid-stream:
   - Stimulus: 5 entries buffered, rst asserted for 1 cycle.
   - Required: valid_out=0, level_out=0, sample_count_out=0, FSM DISABLED; a strobe arriving during rst is ignored.
